// File: rtl/pipeline_defs_pkg.sv
// Shared pipeline encodings: instruction type/number codes, MEM FSM states, stage field bundle.
package pipeline_defs;

  localparam logic [3:0] IT_NOP    = 4'd0;
  localparam logic [3:0] IT_RTYPE  = 4'd1;
  localparam logic [3:0] IT_ITYPE  = 4'd2;
  localparam logic [3:0] IT_LOAD   = 4'd3;
  localparam logic [3:0] IT_STORE  = 4'd4;
  localparam logic [3:0] IT_BRANCH = 4'd5;
  localparam logic [3:0] IT_JUMP   = 4'd6;

  localparam logic [3:0] MN_LB  = 4'd0;
  localparam logic [3:0] MN_LBU = 4'd1;
  localparam logic [3:0] MN_LH  = 4'd2;
  localparam logic [3:0] MN_LHU = 4'd3;
  localparam logic [3:0] MN_LW  = 4'd4;
  localparam logic [3:0] MN_SB  = 4'd5;
  localparam logic [3:0] MN_SH  = 4'd6;
  localparam logic [3:0] MN_SW  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } mem_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] new_pc;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic [3:0]  inst_num;
    logic [3:0]  inst_type;
  } stage_fields_t;

  function automatic logic is_mem(input logic [3:0] inst_type);
    return (inst_type == IT_LOAD) || (inst_type == IT_STORE);
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational lane logic: misalign check, store byte enables/replicated data, load extract and extend.
// Zero latency; no flow control of its own.
module load_store_align
  import pipeline_defs::*;
(
  input  logic [3:0]  inst_type,
  input  logic [3:0]  inst_num,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign half_shift = rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    misaligned = 1'b0;
    be         = 4'hF;
    wdata      = store_data;
    load_data  = rdata;
    case (inst_num)
      MN_LB:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      MN_LBU: load_data = {24'b0, byte_shift[7:0]};
      MN_LH: begin
        misaligned = addr_lo[0];
        load_data  = {{16{half_shift[15]}}, half_shift[15:0]};
      end
      MN_LHU: begin
        misaligned = addr_lo[0];
        load_data  = {16'b0, half_shift[15:0]};
      end
      MN_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MN_SH: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
      end
      default: misaligned = |addr_lo;
    endcase
    // Loads always fetch the whole word; lane selection happens on the way back.
    if (inst_type != IT_STORE) be = 4'hF;
    if (!is_mem(inst_type)) misaligned = 1'b0;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: pass-through for non-memory ops, req/ack data-memory access with timeout for LOAD/STORE.
// Non-memory: 0 latency; memory ops stall upstream until ack, timeout or misalign rejection.
module mem_access_stage
  import pipeline_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FromEXMEM_Inst,
  input  logic [31:0] FromEXMEM_NewPC,
  input  logic [31:0] FromEXMEM_RegDataA,
  input  logic [31:0] FromEXMEM_RegDataB,
  input  logic [31:0] FromEXMEM_Imm,
  input  logic [31:0] FromEXMEM_ALUOutput,
  input  logic [3:0]  FromEXMEM_InstNum,
  input  logic [3:0]  FromEXMEM_InstType,
  output logic [31:0] ToMEMWB_Inst,
  output logic [31:0] ToMEMWB_NewPC,
  output logic [31:0] ToMEMWB_RegDataA,
  output logic [31:0] ToMEMWB_RegDataB,
  output logic [31:0] ToMEMWB_Imm,
  output logic [31:0] ToMEMWB_ALUOutput,
  output logic [3:0]  ToMEMWB_InstNum,
  output logic [3:0]  ToMEMWB_InstType,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_fault
);

  stage_fields_t    in_f, held_f, out_f;
  mem_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      result;
  logic             res_bubble, fault_nx, capture, in_access, timeout_hit;
  logic             al_mis;
  logic [3:0]       al_type, al_num, al_be;
  logic [31:0]      al_addr, al_sdata, al_wdata, al_load;

  assign in_f = {FromEXMEM_Inst, FromEXMEM_NewPC, FromEXMEM_RegDataA, FromEXMEM_RegDataB,
                 FromEXMEM_Imm, FromEXMEM_ALUOutput, FromEXMEM_InstNum, FromEXMEM_InstType};
  assign {ToMEMWB_Inst, ToMEMWB_NewPC, ToMEMWB_RegDataA, ToMEMWB_RegDataB,
          ToMEMWB_Imm, ToMEMWB_ALUOutput, ToMEMWB_InstNum, ToMEMWB_InstType} = out_f;

  // One lane unit serves both the IDLE misalign check (live inputs) and the access (held regs).
  assign al_type  = (state == ST_IDLE) ? in_f.inst_type : held_f.inst_type;
  assign al_num   = (state == ST_IDLE) ? in_f.inst_num  : held_f.inst_num;
  assign al_addr  = (state == ST_IDLE) ? in_f.alu_out   : held_f.alu_out;
  assign al_sdata = (state == ST_IDLE) ? in_f.reg_b     : held_f.reg_b;

  load_store_align u_align (
    .inst_type  (al_type),
    .inst_num   (al_num),
    .addr_lo    (al_addr[1:0]),
    .store_data (al_sdata),
    .rdata      (dmem_rdata),
    .misaligned (al_mis),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign in_access   = (state == ST_ACCESS);
  assign timeout_hit = in_access && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign dmem_req   = in_access;
  assign dmem_we    = in_access && (held_f.inst_type == IT_STORE);
  assign dmem_addr  = in_access ? {held_f.alu_out[31:2], 2'b00} : 32'b0;
  assign dmem_be    = in_access ? al_be : 4'b0;
  assign dmem_wdata = in_access ? al_wdata : 32'b0;

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    out_f    = '0;
    fault_nx = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!is_mem(in_f.inst_type)) begin
          out_f = in_f;
        end else if (al_mis) begin
          fault_nx = 1'b1;
        end else begin
          stall    = 1'b1;
          capture  = 1'b1;
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (dmem_ack) begin
          state_nx = ST_DONE;
        end else if (timeout_hit) begin
          fault_nx = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        if (!res_bubble) begin
          out_f = held_f;
          if (held_f.inst_type == IT_LOAD) out_f.alu_out = result;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      held_f     <= '0;
      result     <= '0;
      res_bubble <= 1'b0;
      cnt        <= '0;
      mem_fault  <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_fault <= fault_nx;
      cnt       <= (in_access && !dmem_ack) ? cnt + CNT_W'(1) : '0;
      if (capture) begin
        held_f     <= in_f;
        res_bubble <= 1'b0;
      end
      if (in_access && dmem_ack) result <= al_load;
      if (timeout_hit) res_bubble <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops against a behavioural model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] from_inst, from_newpc, from_a, from_b, from_imm, from_alu;
  logic [3:0]  from_num, from_type;
  logic [31:0] to_inst, to_newpc, to_a, to_b, to_imm, to_alu;
  logic [3:0]  to_num, to_type;
  logic        dmem_req, dmem_we, dmem_ack, stall, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  logic [199:0] to_vec, got_out;
  int           req_cycles, stall_cycles, fault_cycles;
  bit           bubble_bad, req_unstable;
  logic [31:0]  r_addr, r_wdata;
  logic [3:0]   r_be;
  logic         r_we;

  assign to_vec = {to_inst, to_newpc, to_a, to_b, to_imm, to_alu, to_num, to_type};

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .FromEXMEM_Inst(from_inst), .FromEXMEM_NewPC(from_newpc), .FromEXMEM_RegDataA(from_a),
    .FromEXMEM_RegDataB(from_b), .FromEXMEM_Imm(from_imm), .FromEXMEM_ALUOutput(from_alu),
    .FromEXMEM_InstNum(from_num), .FromEXMEM_InstType(from_type),
    .ToMEMWB_Inst(to_inst), .ToMEMWB_NewPC(to_newpc), .ToMEMWB_RegDataA(to_a),
    .ToMEMWB_RegDataB(to_b), .ToMEMWB_Imm(to_imm), .ToMEMWB_ALUOutput(to_alu),
    .ToMEMWB_InstNum(to_num), .ToMEMWB_InstType(to_type),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_fault(mem_fault)
  );

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [3:0] t, input logic [3:0] n, input logic [31:0] a);
    if (t != 3 && t != 4) return 0;
    if (n == 2 || n == 3 || n == 6) return (a % 2) != 0;
    if (n == 4 || n == 7) return (a % 4) != 0;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] n, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (n == 0 || n == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (n == 0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (n == 2 || n == 3) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (n == 2 && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] t, input logic [3:0] n, input logic [31:0] a);
    if (t == 3) return 4'hF;
    if (n == 5) return 4'(1 << (a % 4));
    if (n == 6) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] n, input logic [31:0] b);
    if (n == 5) return (b & 32'hFF) * 32'h0101_0101;
    if (n == 6) return (b & 32'hFFFF) * 32'h0001_0001;
    return b;
  endfunction

  function automatic logic [199:0] m_out(input logic [199:0] iv, input logic [31:0] rd, input int ack_at);
    logic [199:0] r;
    r = iv;
    if (iv[3:0] != 3 && iv[3:0] != 4) return r;
    if (m_mis(iv[3:0], iv[7:4], iv[39:8]) || ack_at > TO) return '0;
    if (iv[3:0] == 3) r[39:8] = m_load(iv[7:4], iv[39:8], rd);
    return r;
  endfunction

  function automatic logic [199:0] in_vec();
    return {from_inst, from_newpc, from_a, from_b, from_imm, from_alu, from_num, from_type};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input logic [3:0] t, input logic [3:0] n, input logic [31:0] addr, input logic [31:0] b);
    from_inst = $urandom; from_newpc = $urandom; from_a = $urandom; from_b = b;
    from_imm = $urandom; from_alu = addr; from_num = n; from_type = t;
  endtask

  task automatic clear_op();
    from_inst = '0; from_newpc = '0; from_a = '0; from_b = '0;
    from_imm = '0; from_alu = '0; from_num = '0; from_type = '0;
  endtask

  // Runs the op currently on From* (called at posedge+1); memory acks on the ack_at-th request cycle.
  task automatic run_op(input int ack_at, input logic [31:0] rd);
    bit done;
    done = 0; req_cycles = 0; stall_cycles = 0; fault_cycles = 0;
    bubble_bad = 0; req_unstable = 0; got_out = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (dmem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata; r_we = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {r_addr, r_be, r_wdata, r_we}) begin
          req_unstable = 1;
        end
      end
      dmem_ack   = dmem_req && (req_cycles == ack_at);
      dmem_rdata = dmem_ack ? rd : $urandom;
      @(negedge clock);
      if (mem_fault) fault_cycles++;
      if (stall) begin
        stall_cycles++;
        if (to_vec !== '0) bubble_bad = 1;
      end else begin
        got_out = to_vec;
        done = 1;
      end
      @(posedge clock); #1;
      if (done) break;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL completion: stall never released within 40 cycles, want release");
    end
    dmem_ack = 1'b0;
    clear_op();
    repeat (2) begin
      @(negedge clock);
      if (mem_fault) fault_cycles++;
      if (dmem_req) req_cycles++;
      @(posedge clock); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin errors++;
      $display("FAIL reset_dmem: got req=%b we=%b be=%h addr=%h wdata=%h want all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    checks++; if ({stall, mem_fault} !== 2'b00) begin errors++;
      $display("FAIL reset_ctrl: got stall=%b fault=%b want 0 0", stall, mem_fault); end
    checks++; if (to_vec !== '0) begin errors++;
      $display("FAIL reset_to: got %h want 0", to_vec); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({stall, mem_fault, dmem_req} !== 3'b000) begin errors++;
      $display("FAIL post_reset: got stall=%b fault=%b req=%b want 0 0 0", stall, mem_fault, dmem_req); end
    @(posedge clock); #1;
  endtask

  task automatic test_passthrough();
    logic [199:0] iv;
    set_op(4'd1, 4'd3, 32'h1234, $urandom);
    iv = in_vec();
    run_op(1, 32'h0);
    checks++; if (got_out !== iv) begin errors++; $display("FAIL pass_fields: got %h want %h", got_out, iv); end
    checks++; if (got_out[39:8] !== 32'h1234) begin errors++; $display("FAIL pass_alu: got %h want 00001234", got_out[39:8]); end
    checks++; if (stall_cycles != 0 || req_cycles != 0) begin errors++;
      $display("FAIL pass_nostall: got stall_cycles=%0d req_cycles=%0d want 0 0", stall_cycles, req_cycles); end
  endtask

  task automatic test_load_extend();
    set_op(4'd3, 4'd0, 32'h103, $urandom);
    run_op(2, 32'h80FF_FFFF);
    checks++; if (stall_cycles != 3) begin errors++; $display("FAIL lb_stall: got %0d want 3", stall_cycles); end
    checks++; if (got_out[39:8] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", got_out[39:8]); end
    checks++; if (got_out[3:0] !== 4'd3 || fault_cycles != 0) begin errors++;
      $display("FAIL lb_type: got type=%0d faults=%0d want 3 0", got_out[3:0], fault_cycles); end
    set_op(4'd3, 4'd1, 32'h103, $urandom);
    run_op(2, 32'h80FF_FFFF);
    checks++; if (got_out[39:8] !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", got_out[39:8]); end
  endtask

  task automatic test_store_lanes();
    set_op(4'd4, 4'd6, 32'h202, 32'hABCD_1234);
    run_op(1, 32'h0);
    checks++; if ({r_addr, r_be, r_wdata, r_we} !== {32'h200, 4'b1100, 32'h1234_1234, 1'b1}) begin errors++;
      $display("FAIL sh_lanes: got addr=%h be=%b wdata=%h we=%b want 200 1100 12341234 1", r_addr, r_be, r_wdata, r_we); end
    checks++; if (got_out[39:8] !== 32'h202) begin errors++; $display("FAIL sh_alu: got %h want 00000202", got_out[39:8]); end
    set_op(4'd4, 4'd6, 32'h202, 32'hABCD_1234);
    run_op(3, 32'h0);
    checks++; if (req_unstable || req_cycles != 3) begin errors++;
      $display("FAIL sh_stable: got unstable=%b req_cycles=%0d want 0 3", req_unstable, req_cycles); end
  endtask

  task automatic test_misaligned();
    set_op(4'd3, 4'd4, 32'h101, $urandom);
    run_op(1, 32'h0);
    checks++; if (req_cycles != 0) begin errors++; $display("FAIL mis_req: got %0d req cycles want 0", req_cycles); end
    checks++; if (fault_cycles != 1) begin errors++; $display("FAIL mis_fault: got %0d pulse cycles want 1", fault_cycles); end
    checks++; if (got_out !== '0 || stall_cycles != 0) begin errors++;
      $display("FAIL mis_bubble: got out=%h stall_cycles=%0d want 0 0", got_out, stall_cycles); end
  endtask

  task automatic test_timeout();
    set_op(4'd3, 4'd4, 32'h400, $urandom);
    run_op(99, 32'h0);
    checks++; if (req_cycles != TO) begin errors++; $display("FAIL to_req: got %0d want %0d", req_cycles, TO); end
    checks++; if (fault_cycles != 1 || got_out !== '0) begin errors++;
      $display("FAIL to_fault: got faults=%0d out=%h want 1 0", fault_cycles, got_out); end
    set_op(4'd3, 4'd4, 32'h400, $urandom);
    run_op(TO, 32'hCAFE_F00D);
    checks++; if (fault_cycles != 0 || got_out[39:8] !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL to_lastack: got faults=%0d alu=%h want 0 cafef00d", fault_cycles, got_out[39:8]); end
  endtask

  task automatic test_reset_mid_access();
    dmem_ack = 1'b0;
    set_op(4'd3, 4'd4, 32'h40, $urandom);
    repeat (2) @(posedge clock);
    #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre: got req=%b want 1", dmem_req); end
    reset = 1'b1;
    clear_op();
    #1;
    checks++; if ({dmem_req, stall} !== 2'b00) begin errors++;
      $display("FAIL rst_async: got req=%b stall=%b want 0 0", dmem_req, stall); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    set_op(4'd3, 4'd4, 32'h40, $urandom);
    run_op(2, 32'h1357_9BDF);
    checks++; if (got_out[39:8] !== 32'h1357_9BDF || stall_cycles != 3 || fault_cycles != 0) begin errors++;
      $display("FAIL rst_after: got alu=%h stall=%0d faults=%0d want 13579bdf 3 0", got_out[39:8], stall_cycles, fault_cycles); end
  endtask

  task automatic test_random();
    logic [199:0] iv, exp_out;
    logic [3:0]   t, n;
    logic [31:0]  rd, a;
    int           ack_at, exp_stall, exp_req, exp_fault;
    bit           mis;
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom_range(1, 6));
      n = (t == 3) ? 4'($urandom_range(0, 4)) : (t == 4) ? 4'($urandom_range(5, 7)) : 4'($urandom_range(0, 15));
      a = $urandom;
      ack_at = $urandom_range(1, TO + 2);
      rd = $urandom;
      set_op(t, n, a, $urandom);
      iv = in_vec();
      mis = m_mis(t, n, a);
      exp_out = m_out(iv, rd, ack_at);
      if (t != 3 && t != 4 || mis) begin exp_stall = 0; exp_req = 0; end
      else begin exp_req = (ack_at > TO) ? TO : ack_at; exp_stall = exp_req + 1; end
      exp_fault = ((t == 3 || t == 4) && (mis || ack_at > TO)) ? 1 : 0;
      run_op(ack_at, rd);
      checks++; if (got_out !== exp_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h want %h", i, got_out, exp_out); end
      checks++; if (stall_cycles != exp_stall || req_cycles != exp_req) begin errors++;
        $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d want %0d %0d", i, stall_cycles, req_cycles, exp_stall, exp_req); end
      checks++; if (fault_cycles != exp_fault || bubble_bad) begin errors++;
        $display("FAIL rnd_fault[%0d]: got faults=%0d bubble_bad=%b want %0d 0", i, fault_cycles, bubble_bad, exp_fault); end
      if (exp_req > 0) begin
        checks++;
        if ({r_addr, r_be, r_wdata, r_we, req_unstable} !== {a & ~32'h3, m_be(t, n, a), (t == 4) ? m_wdata(n, iv[103:72]) : r_wdata, t == 4, 1'b0}) begin
          errors++;
          $display("FAIL rnd_bus[%0d]: got addr=%h be=%b wdata=%h we=%b unstable=%b want addr=%h be=%b", i,
                   r_addr, r_be, r_wdata, r_we, req_unstable, a & ~32'h3, m_be(t, n, a));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    clear_op();
    test_reset();
    test_passthrough();
    test_load_extend();
    test_store_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
